cby_mem_bank_prog_ctrl: RTL

Programming controller for the memory-bank configuration cells of a Y-direction connection block. It accepts one configuration word per routing multiplexer over a valid/ready stream, then drives the block's flat `bl`/`wl` buses with setup, write-pulse and hold phases for each multiplexer's SRAM group in order. It sits between the fabric-level bitstream loader and one connection-block tile. It signals completion or error to the loader.

---
 rtl/cby_mem_bank_prog_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cby_mem_bank_prog_ctrl.sv
// Memory-bank programming controller for a Y connection block: takes one config word per mux
// and drives bl setup / wl pulse / hold for each SRAM group. Optional CBY_MEM_BANK_PARITY_EN adds even parity and ERR.
module cby_mem_bank_prog_ctrl #(
    parameter int NUM_MUX   = 11,
    parameter int SRAM_W    = 6,
    parameter int PULSE_CYC = 2
) (
    input  logic                      prog_clk,
    input  logic                      prog_reset_n,
    input  logic                      start,
    input  logic                      abort,
`ifdef CBY_MEM_BANK_PARITY_EN
    input  logic [SRAM_W:0]           cfg_data,
`else
    input  logic [SRAM_W-1:0]         cfg_data,
`endif
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    output logic [NUM_MUX*SRAM_W-1:0] bl,
    output logic [NUM_MUX*SRAM_W-1:0] wl,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [2:0]                dbg_state
);

    localparam int BUS_W = NUM_MUX * SRAM_W;
    localparam int IDX_W = (NUM_MUX > 1) ? $clog2(NUM_MUX) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MUX - 1);
    localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SETUP = 3'd2,
        S_PULSE = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5
`ifdef CBY_MEM_BANK_PARITY_EN
        , S_ERR = 3'd6
`endif
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [3:0]         cnt_q;
    logic [BUS_W-1:0]   bl_q;
    logic [BUS_W-1:0]   wl_q;
    logic               cfg_ready_q;
    logic               busy_q;
    logic               done_q;
    logic [BUS_W-1:0]   bl_d;
    logic [BUS_W-1:0]   wl_d;
`ifdef CBY_MEM_BANK_PARITY_EN
    logic               err_q;
    logic               parity_ok_d;
`endif

    // Group images for the current index: incoming word on bl, all-ones on wl.
    always_comb begin
        bl_d = BUS_W'(cfg_data[SRAM_W-1:0]) << (int'(idx_q) * SRAM_W);
        wl_d = BUS_W'({SRAM_W{1'b1}}) << (int'(idx_q) * SRAM_W);
`ifdef CBY_MEM_BANK_PARITY_EN
        parity_ok_d = ~^cfg_data;
`endif
    end

    // Stream handshake: a word transfers on a rising edge where cfg_valid and cfg_ready are both 1;
    // cfg_ready is registered and only high in LOAD, and the source must hold cfg_data stable while
    // cfg_valid is high and cfg_ready is low.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            bl_q        <= '0;
            wl_q        <= '0;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef CBY_MEM_BANK_PARITY_EN
            err_q       <= 1'b0;
`endif
        end else if (busy_q && abort) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            bl_q        <= '0;
            wl_q        <= '0;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (cfg_valid && cfg_ready_q) begin
                        cfg_ready_q <= 1'b0;
`ifdef CBY_MEM_BANK_PARITY_EN
                        if (!parity_ok_d) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else
`endif
                        begin
                            state_q <= S_SETUP;
                            bl_q    <= bl_d;
                        end
                    end
                end
                S_SETUP: begin
                    state_q <= S_PULSE;
                    wl_q    <= wl_d;
                    cnt_q   <= PULSE_LOAD;
                end
                S_PULSE: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_HOLD;
                        wl_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_HOLD: begin
                    bl_q <= '0;
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q       <= idx_q + 1'b1;
                        state_q     <= S_LOAD;
                        cfg_ready_q <= 1'b1;
                    end
                end
                default: begin
                    // IDLE, DONE and ERR all wait here for a new start.
                    if (start) begin
                        state_q     <= S_LOAD;
                        idx_q       <= '0;
                        done_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        cfg_ready_q <= 1'b1;
`ifdef CBY_MEM_BANK_PARITY_EN
                        err_q       <= 1'b0;
`endif
                    end
                end
            endcase
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign bl        = bl_q;
    assign wl        = wl_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;
`ifdef CBY_MEM_BANK_PARITY_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule
